// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM download loader: FSM states and settle timing.
package rom_loader_pkg;

    localparam int unsigned ROM_A_W       = 25;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned SETTLE_CYCLES = 16;
    localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        SETTLE
    } state_e;

endpackage

// File: rtl/rom_fifo.sv
// Small synchronous FIFO buffering download bytes ahead of the memory controller.
module rom_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic             last,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count_c;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_c = wr_ptr - rd_ptr;
    assign full    = (count_c == (PTR_W+1)'(DEPTH));
    assign empty   = (count_c == '0);
    assign last    = (count_c == (PTR_W+1)'(1));
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/rom_loader.sv
// Streams ioctl ROM download bytes into memory and holds the core in reset until done.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W = 18,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter int unsigned       LIMIT  = 32'h10000,
    parameter int unsigned       DEPTH  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               romIo,
    input  logic               romWr,
    input  logic [ROM_A_W-1:0] romA,
    input  logic [DATA_W-1:0]  romD,
    output logic               memReq,
    output logic [ADDR_W-1:0]  memA,
    output logic [DATA_W-1:0]  memD,
    input  logic               memAck,
    output logic               hold,
    output logic               loaded,
    output logic               ovf
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    state_e              state, state_d;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_d;
    logic                hold_d, loaded_d, ovf_d;
    logic                push_c, pop_c, flush_c;
    logic                in_range_c, drain_done_c;
    logic [ENTRY_W-1:0]  entry_c, fifo_head;
    logic                fifo_full, fifo_empty, fifo_last;

    assign in_range_c = (32'(romA) < LIMIT);
    assign entry_c    = {ADDR_W'(BASE + romA[ADDR_W-1:0]), romD};
    assign pop_c      = memReq && memAck;
    // The final ack already leaves nothing queued or in flight.
    assign drain_done_c = memReq ? (memAck && fifo_last) : fifo_empty;

    rom_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush_c),
        .push  (push_c),
        .pop   (pop_c),
        .din   (entry_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .last  (fifo_last),
        .head  (fifo_head)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            hold       <= 1'b1;
            loaded     <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_d;
            settle_cnt <= settle_cnt_d;
            hold       <= hold_d;
            loaded     <= loaded_d;
            ovf        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state;
        settle_cnt_d = settle_cnt;
        hold_d       = hold;
        loaded_d     = loaded;
        ovf_d        = ovf;
        push_c       = 1'b0;
        flush_c      = 1'b0;
        case (state)
            IDLE: begin
                if (romIo) state_d = LOAD;
            end
            LOAD: begin
                if (romWr) begin
                    if (in_range_c && (!fifo_full || pop_c)) push_c = 1'b1;
                    else                                      ovf_d  = 1'b1;
                end
                if (!romIo) state_d = DRAIN;
            end
            DRAIN: begin
                if (romIo) begin
                    state_d = LOAD;
                end else if (drain_done_c) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (romIo) begin
                    state_d = LOAD;
                end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    state_d      = IDLE;
                    settle_cnt_d = '0;
                    hold_d       = 1'b0;
                    loaded_d     = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt + SETTLE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Every fresh download starts from a clean slate, abandoning unwritten bytes.
        if (state_d == LOAD && state != LOAD) begin
            flush_c      = 1'b1;
            ovf_d        = 1'b0;
            loaded_d     = 1'b0;
            hold_d       = 1'b1;
            settle_cnt_d = '0;
        end
    end

    // Request stays frozen on the head entry until acked, then drops for a cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memReq <= 1'b0;
            memA   <= '0;
            memD   <= '0;
        end else if (flush_c) begin
            memReq <= 1'b0;
        end else if (memReq) begin
            if (memAck) memReq <= 1'b0;
        end else if (!fifo_empty) begin
            memReq       <= 1'b1;
            {memA, memD} <= fifo_head;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed and randomized bench for rom_loader against a queue-based reference model.
module tb_rom_loader;

    localparam int unsigned LIMIT  = 32'h10000;
    localparam int unsigned DEPTH  = 4;
    localparam logic [17:0] BASE_B = 18'h04000;

    typedef struct {
        logic [17:0] off;
        logic [7:0]  data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rom_io = 1'b0, rom_wr = 1'b0, mem_ack = 1'b0;
    logic [24:0] rom_a = '0;
    logic [7:0]  rom_d = '0;
    logic        mem_req, hold, loaded, ovf;
    logic [17:0] mem_a;
    logic [7:0]  mem_d;
    logic        mem_req_b, hold_b, loaded_b, ovf_b;
    logic [17:0] mem_a_b;
    logic [7:0]  mem_d_b;

    rom_loader dut (
        .clock(clock), .reset(reset), .romIo(rom_io), .romWr(rom_wr), .romA(rom_a), .romD(rom_d),
        .memReq(mem_req), .memA(mem_a), .memD(mem_d), .memAck(mem_ack),
        .hold(hold), .loaded(loaded), .ovf(ovf)
    );

    rom_loader #(.BASE(BASE_B)) dut_b (
        .clock(clock), .reset(reset), .romIo(rom_io), .romWr(rom_wr), .romA(rom_a), .romD(rom_d),
        .memReq(mem_req_b), .memA(mem_a_b), .memD(mem_d_b), .memAck(mem_ack),
        .hold(hold_b), .loaded(loaded_b), .ovf(ovf_b)
    );

    always #5 clock = ~clock;

    int          errors = 0, checks = 0, cyc = 0;
    int          age = 0, ack_delay = 2, rises = 0, writes = 0, accepted = 0, last_ack_cyc = 0;
    bit          stall = 0, spurious = 0, rand_delay = 0, ack_prev = 0, req_seen = 0, model_ovf = 0;
    logic [17:0] held_a = '0, last_b_addr = '0;
    logic [7:0]  held_d = '0;
    exp_t        q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, play memory controller, then drive inputs.
    task automatic tick(input bit wr, input logic [24:0] a, input logic [7:0] d);
        bit   ack_now;
        exp_t e;
        @(negedge clock);
        cyc++;
        ack_now = 0;
        if (ack_prev) check("req_gap", 32'(mem_req), 0);
        if (mem_req && !ack_prev) begin
            if (!req_seen) begin
                req_seen = 1;
                age      = 0;
                rises++;
                if (rand_delay) ack_delay = $urandom_range(1, 4);
                check("req_has_entry", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    check("wr_addr", 32'(mem_a), 32'(q[0].off));
                    check("wr_data", 32'(mem_d), 32'(q[0].data));
                    check("wr_addr_base", 32'(mem_a_b), 32'(18'(q[0].off + BASE_B)));
                end
                held_a = mem_a;
                held_d = mem_d;
            end else begin
                check("stable_addr", 32'(mem_a), 32'(held_a));
                check("stable_data", 32'(mem_d), 32'(held_d));
            end
            age++;
            if (!stall && age >= ack_delay) begin
                ack_now = 1;
                if (q.size() != 0) void'(q.pop_front());
                writes++;
                last_ack_cyc = cyc;
                last_b_addr  = mem_a_b;
                req_seen     = 0;
            end
        end
        ack_prev = ack_now;
        mem_ack  = ack_now || (!mem_req && spurious && $urandom_range(0, 3) == 0);
        rom_wr   = wr;
        rom_a    = a;
        rom_d    = d;
        if (wr) begin
            if (32'(a) < LIMIT && q.size() < DEPTH) begin
                e.off  = a[17:0];
                e.data = d;
                q.push_back(e);
                accepted++;
            end else begin
                model_ovf = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, '0);
    endtask

    task automatic begin_load();
        rom_io    = 1'b1;
        model_ovf = 0;
        writes    = 0;
        accepted  = 0;
        rises     = 0;
        idle(3);
    endtask

    task automatic wait_loaded(output int at);
        int n;
        n = 0;
        while (loaded !== 1'b1 && n < 400) begin
            tick(0, '0, '0);
            n++;
        end
        if (n >= 400) check("loaded_timeout", 0, 1);
        at = cyc;
    endtask

    initial begin
        int          at;
        logic [24:0] a;
        logic [7:0]  d;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", 32'(mem_a), 0);
        check("rst_hold", 32'(hold), 1);
        check("rst_loaded", 32'(loaded), 0);
        check("rst_ovf", 32'(ovf), 0);
        reset = 1'b1;

        // Idle for 100 cycles
        idle(100);
        check("idle_hold", 32'(hold), 1);
        check("idle_loaded", 32'(loaded), 0);
        check("idle_req", 32'(mem_req), 0);

        // Sequential download with fixed ack latency, checking settle timing
        ack_delay = 2;
        begin_load();
        for (int i = 0; i < 16; i++) begin
            tick(1, 25'(i), 8'(i) ^ 8'hA5);
            if (i < 15) idle(7);
        end
        rom_io = 1'b0;
        wait_loaded(at);
        check("seq_writes", 32'(writes), 16);
        check("seq_accepted", 32'(accepted), 16);
        check("seq_settle", 32'(at - last_ack_cyc), 17);
        check("seq_hold", 32'(hold), 0);
        check("seq_ovf", 32'(ovf), 0);

        // Limit boundary with a non-zero base
        begin_load();
        tick(1, 25'h0FFFF, 8'($urandom));
        idle(5);
        tick(1, 25'h10000, 8'($urandom));
        rom_io = 1'b0;
        tick(0, '0, '0);
        check("lim_ovf_early", 32'(ovf), 1);
        wait_loaded(at);
        check("lim_writes", 32'(writes), 1);
        check("lim_base_addr", 32'(last_b_addr), 32'h13FFF);
        check("lim_ovf", 32'(ovf_b), 1);
        check("lim_loaded", 32'(loaded_b), 1);

        // Memory stall while the FIFO overflows
        begin_load();
        stall = 1;
        for (int i = 0; i < 6; i++) begin
            tick(1, 25'(i), 8'($urandom));
            idle(1);
        end
        idle(8);
        stall = 0;
        rom_io = 1'b0;
        wait_loaded(at);
        check("stall_writes", 32'(writes), 4);
        check("stall_model_ovf", 32'(model_ovf), 1);
        check("stall_ovf", 32'(ovf), 1);

        // Reset in the middle of the third pending request
        ack_delay = 4;
        begin_load();
        tick(1, 25'h1000000, 8'h00);
        for (int k = 0; k < 60 && rises < 3; k++)
            tick(k < 12 && k % 2 == 0, 25'(k / 2 + 32'h20), 8'(k));
        check("pre_rst_req", 32'(mem_req), 1);
        check("pre_rst_ovf", 32'(ovf), 1);
        reset  = 1'b0;
        rom_io = 1'b0;
        rom_wr = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 0);
        check("mid_rst_addr", 32'(mem_a), 0);
        check("mid_rst_data", 32'(mem_d), 0);
        check("mid_rst_hold", 32'(hold), 1);
        check("mid_rst_loaded", 32'(loaded), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        q.delete();
        req_seen = 0;
        ack_prev = 0;
        idle(2);
        reset = 1'b1;
        ack_delay = 2;
        begin_load();
        check("post_rst_ovf", 32'(ovf), 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 25'(32'h100 + i), 8'($urandom));
            idle(3);
        end
        rom_io = 1'b0;
        wait_loaded(at);
        check("post_rst_writes", 32'(writes), 4);
        check("post_rst_ovf_end", 32'(ovf), 0);

        // New download requested during SETTLE
        begin_load();
        for (int i = 0; i < 4; i++) begin
            tick(1, 25'($urandom_range(0, 32'hFFFF)), 8'($urandom));
            idle(3);
        end
        rom_io = 1'b0;
        for (int n = 0; n < 50 && q.size() != 0; n++) tick(0, '0, '0);
        idle(5);
        check("settle_loaded", 32'(loaded), 0);
        check("settle_hold", 32'(hold), 1);
        begin_load();
        check("reload_hold", 32'(hold), 1);
        check("reload_loaded", 32'(loaded), 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 25'($urandom_range(0, 32'hFFFF)), 8'($urandom));
            idle(2);
        end
        rom_io = 1'b0;
        wait_loaded(at);
        check("reload_writes", 32'(writes), 4);
        check("reload_hold_end", 32'(hold), 0);

        // Randomized traffic: bursty strobes, variable ack latency, stray acks
        rand_delay = 1;
        spurious   = 1;
        begin_load();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) a = 25'($urandom_range(32'h10000, 32'h1FFFFFF));
            else                           a = 25'($urandom_range(0, 32'hFFFF));
            d = 8'($urandom);
            tick(1, a, d);
            idle($urandom_range(0, 3));
        end
        rom_io = 1'b0;
        wait_loaded(at);
        spurious = 0;
        rand_delay = 0;
        check("rand_writes", 32'(writes), 32'(accepted));
        check("rand_queue", 32'(q.size()), 0);
        check("rand_ovf", 32'(ovf), 32'(model_ovf));
        check("rand_hold", 32'(hold), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
